// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller and the cipher core.
//   AES_NR      : number of AES-128 rounds
//   rkey_t      : one 128-bit round key
//   ks_state_e  : key-schedule controller states
//   xtime()     : multiply by x in GF(2^8)
//   sbox()      : AES forward S-box, computed as GF(2^8) inverse followed by the affine map
package aes_pkg;

    localparam int unsigned AES_NR = 10;

    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_DONE
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = '0;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Inverse as b^254 = b^2 * b^4 * ... * b^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] inv;
        p   = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: applies the AES S-box to each byte of a 32-bit word.
// Shared by the key schedule and the cipher SubBytes stage.
//   word_in  : input word
//   word_out : S-box substituted word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign word_out[8*i +: 8] = sbox(word_in[8*i +: 8]);
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES-128 key-schedule controller. Accepts a cipher key, expands one round key
// per clock into an (NR+1)-entry table, then serves round keys through a registered read port.
//   clk, rst       : clock, asynchronous active-high reset
//   key_valid/key_ready/key_in : cipher key handshake (word0 = key_in[127:96])
//   clear          : synchronous flush of the table, returns to idle
//   busy           : expansion in progress
//   keys_ready     : all round keys valid
//   rd_en, rd_idx  : round-key read request
//   rd_data, rd_valid, rd_err : read response, one cycle after rd_en, held until next rd_en
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [127:0]     key_in,
    input  logic             clear,
    output logic             busy,
    output logic             keys_ready,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_data,
    output logic             rd_valid,
    output logic             rd_err
);

    ks_state_e        state_q, state_d;
    logic [IDX_W-1:0] rcnt_q;
    logic [7:0]       rcon_q;
    rkey_t            rk_q [0:NR];

    logic             accept;
    logic             last_round;
    logic             rd_ok;
    rkey_t            prev_rk;
    rkey_t            next_rk;
    logic [31:0]      sub_out;
    logic [31:0]      t, n0, n1, n2, n3;

    assign key_ready  = (state_q != KS_EXPAND);
    assign busy       = (state_q == KS_EXPAND);
    assign keys_ready = (state_q == KS_DONE);
    // clear wins over a simultaneous key accept
    assign accept     = key_valid && key_ready && !clear;
    assign last_round = (rcnt_q == IDX_W'(NR));

    // Round-key datapath: derive rk[rcnt] from rk[rcnt-1]
    assign prev_rk = rk_q[rcnt_q - 1'b1];

    aes_sub_word u_sub_word (
        .word_in  ({prev_rk[23:0], prev_rk[31:24]}),
        .word_out (sub_out)
    );

    assign t       = sub_out ^ {rcon_q, 24'h0};
    assign n0      = prev_rk[127:96] ^ t;
    assign n1      = prev_rk[95:64]  ^ n0;
    assign n2      = prev_rk[63:32]  ^ n1;
    assign n3      = prev_rk[31:0]   ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KS_IDLE, KS_DONE: if (accept) state_d = KS_EXPAND;
            KS_EXPAND:        if (last_round) state_d = KS_DONE;
            default:          state_d = KS_IDLE;
        endcase
        if (clear) state_d = KS_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= KS_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
            rcon_q <= 8'h01;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else if (clear) begin
            rcnt_q <= '0;
            rcon_q <= 8'h01;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else if (accept) begin
            rk_q[0] <= key_in;
            rcnt_q  <= IDX_W'(1);
            rcon_q  <= 8'h01;
        end else if (state_q == KS_EXPAND) begin
            rk_q[rcnt_q] <= next_rk;
            rcon_q       <= xtime(rcon_q);
            rcnt_q       <= rcnt_q + 1'b1;
        end
    end

    // A read on the accept edge of a new key already sees the table as not ready;
    // a read alongside clear still sees the pre-clear table.
    assign rd_ok = keys_ready && !accept && (rd_idx <= IDX_W'(NR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= rd_ok ? rk_q[rd_idx] : '0;
            rd_valid <= rd_ok;
            rd_err   <= !rd_ok;
        end
    end

endmodule
